// File: rtl/mac_serial2d_pkg.sv
// Shared widths, mode codes and mode decode for the nibble-serial MAC.
package mac_serial2d_pkg;

  localparam int NIBBLE_W = 4;
  localparam int PP_W     = 9;
  localparam int PROD_W   = 17;
  localparam int ACC_W    = 20;

  localparam logic [2:0] MODE_A8W8 = 3'b000;
  localparam logic [2:0] MODE_A8W4 = 3'b001;
  localparam logic [2:0] MODE_A4W4 = 3'b111;

  typedef enum logic [1:0] {
    PREC_A8W8,
    PREC_A8W4,
    PREC_A4W4
  } prec_e;

  // Unlisted mode codes fall back to full 8x8 precision.
  function automatic prec_e decode_mode(input logic [2:0] m);
    prec_e p;
    case (m)
      MODE_A8W4: p = PREC_A8W4;
      MODE_A4W4: p = PREC_A4W4;
      default:   p = PREC_A8W8;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mac_nibble_mult.sv
// 4-bit unsigned activation nibble times 4-bit weight nibble (signed or unsigned) -> 9-bit signed.
// Purely combinational.
module mac_nibble_mult
  import mac_serial2d_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a_nib,
  input  logic [NIBBLE_W-1:0] i_w_nib,
  input  logic                i_w_signed,
  output logic [PP_W-1:0]     o_pp
);

  logic signed [PP_W-1:0] w_a_ext;
  logic signed [PP_W-1:0] w_w_ext;
  logic signed [PP_W-1:0] w_prod;

  assign w_a_ext = {{(PP_W-NIBBLE_W){1'b0}}, i_a_nib};
  assign w_w_ext = {{(PP_W-NIBBLE_W){i_w_signed & i_w_nib[NIBBLE_W-1]}}, i_w_nib};

  // Range is -120..225, so the 9-bit truncated product is exact.
  assign w_prod = w_a_ext * w_w_ext;
  assign o_pp   = w_prod;

endmodule

// File: rtl/mac_serial2d.sv
// Nibble-serial multiply-accumulate: one 4x4 partial product per cycle, shifted into a
// 17-bit product register and folded into a 20-bit wrapping accumulator on rst_mult.
module mac_serial2d
  import mac_serial2d_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic             rst_mult,
  input  logic             shift_ctr,
  input  logic             sign_ctr,
  input  logic             a_sel,
  input  logic             w_sel,
  input  logic [7:0]       a,
  input  logic [7:0]       w,
  output logic [ACC_W-1:0] z
);

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_w_nib;
  logic [PP_W-1:0]     w_pp;
  logic [PROD_W-1:0]   w_pp_ext;
  logic [PROD_W-1:0]   w_pp_sh;
  logic [ACC_W-1:0]    w_p_ext;
  prec_e               w_prec;
  logic                w_pa;
  logic                w_pw;
  logic [1:0]          w_shamt;

  logic [PROD_W-1:0]   r_p;
  logic [ACC_W-1:0]    r_acc;

  assign w_a_nib = a_sel ? a[7:4] : a[3:0];
  assign w_w_nib = w_sel ? w[7:4] : w[3:0];

  mac_nibble_mult u_mult (
    .i_a_nib    (w_a_nib),
    .i_w_nib    (w_w_nib),
    .i_w_signed (sign_ctr),
    .o_pp       (w_pp)
  );

  // Positions are forced high in reduced-precision modes so results land at the top.
  assign w_prec  = decode_mode(mode);
  assign w_pa    = (w_prec == PREC_A4W4) ? 1'b1 : a_sel;
  assign w_pw    = (w_prec != PREC_A8W8) ? 1'b1 : w_sel;
  assign w_shamt = {1'b0, w_pa} + {1'b0, w_pw};

  assign w_pp_ext = {{(PROD_W-PP_W){w_pp[PP_W-1]}}, w_pp};

  always_comb begin
    w_pp_sh = w_pp_ext;
    case (w_shamt)
      2'd1:    w_pp_sh = w_pp_ext << 4;
      2'd2:    w_pp_sh = w_pp_ext << 8;
      default: w_pp_sh = w_pp_ext;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p   <= '0;
      r_acc <= '0;
    end else if (!shift_ctr) begin
      if (rst_mult) begin
        r_acc <= r_acc + w_p_ext;
        r_p   <= w_pp_sh;
      end else begin
        r_p   <= r_p + w_pp_sh;
      end
    end
  end

  assign w_p_ext = {{(ACC_W-PROD_W){r_p[PROD_W-1]}}, r_p};
  assign z       = r_acc + w_p_ext;

endmodule

// File: tb/tb_mac_serial2d.sv
// Directed bench for mac_serial2d: running-sum model checked every cycle plus literal checkpoints.
module tb_mac_serial2d;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic        rst_mult = 1'b0;
  logic        shift_ctr = 1'b0;
  logic        sign_ctr = 1'b0;
  logic        a_sel = 1'b0;
  logic        w_sel = 1'b0;
  logic [7:0]  a = 8'd0;
  logic [7:0]  w = 8'd0;
  logic [19:0] z;

  int errors = 0;
  int checks = 0;
  int model_z = 0;
  int prod_sum = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mac_serial2d dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .rst_mult  (rst_mult),
    .shift_ctr (shift_ctr),
    .sign_ctr  (sign_ctr),
    .a_sel     (a_sel),
    .w_sel     (w_sel),
    .a         (a),
    .w         (w),
    .z         (z)
  );

  function automatic int wrap20(input int v);
    logic [19:0] t;
    int r;
    t = v[19:0];
    r = {{12{t[19]}}, t};
    return r;
  endfunction

  function automatic int z_int();
    int r;
    r = {{12{z[19]}}, z};
    return r;
  endfunction

  // Value a single sampled cycle adds to the running total.
  function automatic int contrib(input logic [2:0] md, input logic as, input logic ws,
                                 input logic sg, input logic [7:0] av, input logic [7:0] wv);
    int an, wn, pa, pw;
    an = as ? int'(av[7:4]) : int'(av[3:0]);
    wn = ws ? int'(wv[7:4]) : int'(wv[3:0]);
    if (sg && wn >= 8) wn -= 16;
    pa = (md == 3'b111) ? 1 : int'(as);
    pw = (md == 3'b001 || md == 3'b111) ? 1 : int'(ws);
    return an * wn * (1 << (4 * (pa + pw)));
  endfunction

  // Whole-multiplication result as arithmetic on the operands.
  function automatic int full_product(input logic [2:0] md, input logic [7:0] av,
                                      input logic [7:0] wv);
    int w8, w4;
    w8 = int'(wv);
    if (w8 >= 128) w8 -= 256;
    w4 = int'(wv[3:0]);
    if (w4 >= 8) w4 -= 16;
    case (md)
      3'b001:  return int'(av) * w4 * 16;
      3'b111:  return int'(av[3:0]) * w4 * 256;
      default: return int'(av) * w8;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: z=%0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) check("z_model", z_int(), wrap20(model_z));
  end

  task automatic cyc(input logic rn, input logic rm, input logic sc, input logic as,
                     input logic ws, input logic sg, input logic [7:0] av, input logic [7:0] wv);
    rst_n = rn; rst_mult = rm; shift_ctr = sc;
    a_sel = as; w_sel = ws; sign_ctr = sg; a = av; w = wv;
    @(posedge clk);
    if (!rn) begin
      model_z = 0;
      prod_sum = 0;
    end else if (!sc) begin
      model_z += contrib(mode, as, ws, sg, av, wv);
    end
    #2;
  endtask

  task automatic do_reset(input logic [2:0] md);
    mode = md;
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
  endtask

  task automatic stall_cycle();
    cyc(1'b1, 1'($urandom), 1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
        8'($urandom), 8'($urandom));
  endtask

  task automatic mult(input logic [7:0] av, input logic [7:0] wv, input bit stall);
    case (mode)
      3'b001: begin
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, av, wv);
        if (stall) stall_cycle();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, av, wv);
      end
      3'b111: begin
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, av, wv);
        if (stall) stall_cycle();
      end
      default: begin
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, av, wv);
        if (stall) stall_cycle();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, av, wv);
        if (stall) begin stall_cycle(); stall_cycle(); end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, av, wv);
        if (stall) stall_cycle();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, av, wv);
      end
    endcase
    prod_sum += full_product(mode, av, wv);
    check("product_sum", z_int(), wrap20(prod_sum));
  endtask

  initial begin
    do_reset(3'b000);
    check("reset_z", z_int(), 0);
    chk_en = 1'b1;

    // a=200, w=-3, stepwise
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd200, 8'hFD);
    check("a8w8_step1", z_int(), 104);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd200, 8'hFD);
    check("a8w8_step2", z_int(), 2600);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd200, 8'hFD);
    check("a8w8_step3", z_int(), 2472);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd200, 8'hFD);
    check("a8w8_step4", z_int(), -600);
    check("model_pin_a8w8", wrap20(model_z), -600);

    do_reset(3'b111);
    check("reset_z2", z_int(), 0);
    mult(8'h0F, 8'h08, 1'b0);
    check("a4w4_first", z_int(), -30720);
    mult(8'h0F, 8'h08, 1'b0);
    check("a4w4_second", z_int(), -61440);

    do_reset(3'b001);
    mult(8'd255, 8'h07, 1'b0);
    check("a8w4", z_int(), 28560);

    do_reset(3'b000);
    mult(8'd200, 8'hFD, 1'b1);
    check("a8w8_stalled", z_int(), -600);

    do_reset(3'b100);
    mult(8'd200, 8'hFD, 1'b0);
    check("mode100_as_000", z_int(), -600);

    do_reset(3'b000);
    for (int i = 0; i < 40; i++) mult(8'd255, 8'd127, 1'b0);
    check("wrap_40x", z_int(), 246824);
    for (int i = 0; i < 10; i++) mult(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255, 8'd127);
    check("reset_after_acc", z_int(), 0);

    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd200, 8'hFD);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd200, 8'hFD);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd200, 8'hFD);
    check("reset_mid_mult", z_int(), 0);
    mult(8'd255, 8'h80, 1'b0);
    check("after_mid_reset", z_int(), -32640);

    chk_en = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
